// File: rtl/ring_phase_monitor.sv
// Watches a one-hot ring counter: decodes phase, counts revolutions, reports lock and sticky faults.
// Optional macro RING_HOLD_ALLOW_EN: a repeated sample (clock-enabled ring) is treated as legal.
module ring_phase_monitor #(
    parameter int WIDTH    = 4,
    parameter int REV_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] phase,
    output logic                     phase_valid,
    output logic                     wrap_pulse,
    output logic [REV_W-1:0]         rev_count,
    output logic                     locked,
    output logic                     err_onehot,
    output logic                     err_seq
);
    // state  | meaning
    // IDLE   | no valid previous sample; first legal sample starts tracking
    // TRACK  | sequence checked, counting error-free wraps toward lock
    // LOCKED | LOCK_CNT clean wraps seen, ring considered healthy
    // FAULT  | illegal or out-of-order sample seen; waits for clr
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED, FAULT} state_t;

    localparam int PW = $clog2(WIDTH);
    localparam int GW = $clog2(LOCK_CNT + 1);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [GW-1:0]    good_wraps;

    logic             onehot;
    logic             is_step;
    logic             is_wrap;
    logic             hold_ok;
    logic             seq_ok;
    logic [PW-1:0]    dec;

    assign onehot  = (count_in != '0) && ((count_in & (count_in - WIDTH'(1))) == '0);
    assign is_step = onehot && (count_in == {prev[0], prev[WIDTH-1:1]});
    assign is_wrap = is_step && prev[0];

`ifdef RING_HOLD_ALLOW_EN
    assign hold_ok = onehot && (count_in == prev);
`else
    assign hold_ok = 1'b0;
`endif

    assign seq_ok = is_step || hold_ok;

    // Highest bit is phase 0, lowest bit is phase WIDTH-1.
    always_comb begin
        dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (count_in[i]) dec = PW'(WIDTH - 1 - i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            prev        <= '0;
            good_wraps  <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            wrap_pulse  <= 1'b0;
            rev_count   <= '0;
            locked      <= 1'b0;
            err_onehot  <= 1'b0;
            err_seq     <= 1'b0;
        end else begin
            prev       <= count_in;
            wrap_pulse <= 1'b0;
            if (clr) begin
                state       <= IDLE;
                good_wraps  <= '0;
                phase_valid <= 1'b0;
                rev_count   <= '0;
                locked      <= 1'b0;
                err_onehot  <= 1'b0;
                err_seq     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (onehot) begin
                            state       <= TRACK;
                            phase       <= dec;
                            phase_valid <= 1'b1;
                        end else begin
                            err_onehot  <= 1'b1;
                            phase_valid <= 1'b0;
                        end
                    end
                    TRACK, LOCKED: begin
                        if (!onehot || !seq_ok) begin
                            if (!onehot) err_onehot <= 1'b1;
                            else         err_seq    <= 1'b1;
                            state       <= FAULT;
                            locked      <= 1'b0;
                            phase_valid <= 1'b0;
                        end else begin
                            phase       <= dec;
                            phase_valid <= 1'b1;
                            if (is_wrap) begin
                                wrap_pulse <= 1'b1;
                                if (rev_count != '1) rev_count <= rev_count + 1'b1;
                                if (state == TRACK) begin
                                    good_wraps <= good_wraps + 1'b1;
                                    if (good_wraps == GW'(LOCK_CNT - 1)) begin
                                        state  <= LOCKED;
                                        locked <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    FAULT: begin
                        phase_valid <= 1'b0;
                        locked      <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor; a second instance with REV_W=2 covers revolution saturation.
module tb_ring_phase_monitor;
    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       clr;

    logic [1:0] phase,       phase_s;
    logic       phase_valid, phase_valid_s;
    logic       wrap_pulse,  wrap_pulse_s;
    logic [7:0] rev_count;
    logic [1:0] rev_count_s;
    logic       locked,      locked_s;
    logic       err_onehot,  err_onehot_s;
    logic       err_seq,     err_seq_s;

    int ncmp = 0;
    int nerr = 0;

    ring_phase_monitor #(.WIDTH(4), .REV_W(8), .LOCK_CNT(2)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .clr(clr),
        .phase(phase), .phase_valid(phase_valid), .wrap_pulse(wrap_pulse),
        .rev_count(rev_count), .locked(locked), .err_onehot(err_onehot), .err_seq(err_seq)
    );

    ring_phase_monitor #(.WIDTH(4), .REV_W(2), .LOCK_CNT(2)) dut_s (
        .clk(clk), .rst(rst), .count_in(count_in), .clr(clr),
        .phase(phase_s), .phase_valid(phase_valid_s), .wrap_pulse(wrap_pulse_s),
        .rev_count(rev_count_s), .locked(locked_s), .err_onehot(err_onehot_s), .err_seq(err_seq_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] v, input logic c);
        count_in = v;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic pv, input logic lk,
                             input logic eo, input logic es);
        chk({tag, "_pv"}, phase_valid, pv);
        chk({tag, "_locked"}, locked, lk);
        chk({tag, "_err_onehot"}, err_onehot, eo);
        chk({tag, "_err_seq"}, err_seq, es);
    endtask

    // From IDLE: two full revolutions ending on 1000 -> LOCKED.
    task automatic lock_up();
        logic [3:0] ring [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int k = 0; k <= 8; k++) tick(ring[k % 4], 1'b0);
    endtask

    initial begin
        logic [3:0] ring [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        rst      = 1'b0;
        count_in = 4'b0000;
        clr      = 1'b0;
        #12;
        chk("rst_phase", phase, 0);
        chk("rst_wrap", wrap_pulse, 0);
        chk("rst_rev", rev_count, 0);
        chk_flags("rst", 0, 0, 0, 0);
        chk("rst_rev_s", rev_count_s, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Clean rotation: 21 samples, 5 wraps.
        for (int k = 0; k <= 20; k++) begin
            tick(ring[k % 4], 1'b0);
            chk($sformatf("run%0d_phase", k), phase, k % 4);
            chk($sformatf("run%0d_pv", k), phase_valid, 1);
            chk($sformatf("run%0d_wrap", k), wrap_pulse, (k > 0 && k % 4 == 0));
            chk($sformatf("run%0d_rev", k), rev_count, k / 4);
            chk($sformatf("run%0d_locked", k), locked, k >= 8);
            chk($sformatf("run%0d_wrap_s", k), wrap_pulse_s, (k > 0 && k % 4 == 0));
            chk($sformatf("run%0d_rev_s", k), rev_count_s, (k / 4 > 3) ? 3 : k / 4);
        end
        chk("run_errs", {err_onehot, err_seq}, 0);

        // Asynchronous reset mid-cycle while LOCKED with rev_count=5.
        #3 rst = 1'b0;
        #1;
        chk("arst_phase", phase, 0);
        chk("arst_wrap", wrap_pulse, 0);
        chk("arst_rev", rev_count, 0);
        chk_flags("arst", 0, 0, 0, 0);
        #2 rst = 1'b1;
        tick(4'b0010, 1'b0);
        chk("rel_phase", phase, 2);
        chk_flags("rel", 1, 0, 0, 0);
        tick(4'b0001, 1'b0);
        tick(4'b1000, 1'b0);
        chk("rel_wrap1_rev", rev_count, 1);
        chk("rel_wrap1_locked", locked, 0);
        tick(4'b0100, 1'b0);
        tick(4'b0010, 1'b0);
        tick(4'b0001, 1'b0);
        tick(4'b1000, 1'b0);
        chk("rel_wrap2_rev", rev_count, 2);
        chk("rel_wrap2_locked", locked, 1);

        // Hold 0100 for three cycles while LOCKED.
        tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b0);
`ifdef RING_HOLD_ALLOW_EN
        chk("hold_phase", phase, 1);
        chk_flags("hold", 1, 1, 0, 0);
`else
        chk_flags("hold", 0, 0, 0, 1);
`endif

        tick(4'b0100, 1'b1);
        chk("clr1_rev", rev_count, 0);
        chk_flags("clr1", 0, 0, 0, 0);

        // Illegal sample while LOCKED, then legal samples leave flags set.
        lock_up();
        chk("lock_locked", locked, 1);
        tick(4'b1100, 1'b0);
        chk_flags("ill", 0, 0, 1, 0);
        tick(4'b0100, 1'b0);
        tick(4'b0010, 1'b0);
        chk_flags("ill_after", 0, 0, 1, 0);
        chk("ill_after_wrap", wrap_pulse, 0);
        tick(4'b0001, 1'b1);
        chk("clr2_rev", rev_count, 0);
        chk_flags("clr2", 0, 0, 0, 0);

        // Skipped phase in TRACK.
        tick(4'b1000, 1'b0);
        chk_flags("skip_start", 1, 0, 0, 0);
        tick(4'b0010, 1'b0);
        chk_flags("skip", 0, 0, 0, 1);
        tick(4'b0001, 1'b0);
        tick(4'b1000, 1'b0);
        chk("fault_no_wrap", wrap_pulse, 0);
        chk("fault_rev", rev_count, 0);

        // Illegal first sample in IDLE, then recovery into TRACK.
        tick(4'b0000, 1'b1);
        chk_flags("clr3", 0, 0, 0, 0);
        tick(4'b0000, 1'b0);
        chk_flags("idle_ill", 0, 0, 1, 0);
        tick(4'b0100, 1'b0);
        chk("idle_rec_phase", phase, 1);
        chk_flags("idle_rec", 1, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Downstream consumer of the 4-bit one-hot ring counter output `count`.
- Checks that the ring is legal: exactly one bit set, rotating right by one position (1000→0100→0010→0001→1000).
- Converts the one-hot code to a binary phase index and counts full revolutions.
- Raises a lock indication and sticky fault flags for the sequencing logic that consumes the ring.

Parameters:
- WIDTH, 4, ring length and width of count_in; must be ≥2.
- REV_W, 8, width of the revolution counter.
- LOCK_CNT, 2, consecutive error-free wraps required before asserting locked; must be ≥1.

Ports:
- clk  input  1  rising-edge clock, same clock as the ring counter.
- rst  input  1  reset, asynchronous, active-low; all state is cleared while rst=0.
- count_in  input  WIDTH  one-hot ring value; sampled every rising clk edge.
- clr  input  1  synchronous clear of the FSM, counters and sticky flags.
- phase  output  $clog2(WIDTH)  binary index of the set bit; bit WIDTH-1 gives 0, bit 0 gives WIDTH-1.
- phase_valid  output  1  phase holds a legal decoded value.
- wrap_pulse  output  1  one-cycle pulse on a legal step from bit0 to bit WIDTH-1.
- rev_count  output  REV_W  number of legal wraps, saturating.
- locked  output  1  FSM is in LOCKED.
- err_onehot  output  1  sticky: a non-one-hot sample was seen.
- err_seq  output  1  sticky: a one-hot sample that is not a legal successor was seen.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - phase=0, phase_valid=0, wrap_pulse=0, rev_count=0, locked=0, err_onehot=0, err_seq=0.
  - FSM state = IDLE; prev register = 0; good-wrap counter = 0.
- Deassertion of rst takes effect at the next rising clk edge.
- Each edge, count_in is classified against prev:
  - ILLEGAL: popcount ≠ 1.
  - STEP: count_in equals prev rotated right by one.
  - HOLD: count_in equals prev.
  - BAD: any other one-hot value.
- prev loads count_in every cycle, whatever the classification.
- All outputs are registered; latency is one cycle from the count_in sample to phase, wrap_pulse and flag updates.
- FSM transitions:
  - IDLE: a legal one-hot sample goes to TRACK (no sequence check, since there is no valid prev); an ILLEGAL sample stays in IDLE and sets err_onehot.
  - TRACK: STEP or HOLD stays. Each wrap STEP increments the good-wrap counter; when it reaches LOCK_CNT, go to LOCKED. ILLEGAL or BAD goes to FAULT.
  - LOCKED: STEP or HOLD stays; ILLEGAL or BAD goes to FAULT.
  - FAULT: stays until clr=1.
- Error flags:
  - ILLEGAL sets err_onehot; BAD sets err_seq.
  - Both flags are sticky until clr or reset.
- phase / phase_valid:
  - phase updates and phase_valid=1 on any legal one-hot sample in IDLE, TRACK or LOCKED.
  - phase_valid=0 in FAULT, and in IDLE after an ILLEGAL sample.
- wrap_pulse: asserted for exactly one cycle on a STEP from bit0 to bit WIDTH-1 in TRACK or LOCKED. rev_count increments in the same cycle.
- rev_count saturation: holds at 2^REV_W-1; further wraps still pulse wrap_pulse but do not change rev_count.
- clr:
  - Has priority over classification in the same cycle.
  - Clears rev_count, the good-wrap counter, locked and both error flags; FSM goes to IDLE; phase_valid=0.
  - prev still loads count_in.
- Simultaneous ILLEGAL and wrap cannot occur, since an ILLEGAL sample is never a STEP.
- Reset mid-revolution: everything clears immediately. The first legal sample after release re-enters TRACK from IDLE, with no error raised.

Optional Feature:
- Macro: RING_HOLD_ALLOW_EN.
- Defined: HOLD is legal, as described above. Use this when the ring counter is clock-enabled.
- Not defined: HOLD is classified as BAD and sets err_seq; the FSM goes to FAULT from TRACK or LOCKED. In IDLE, HOLD is simply a legal first sample.

Test Plan:
- Reset, then drive 1000,0100,0010,0001 repeatedly → phase=0,1,2,3 one cycle later. wrap_pulse on each 0001→1000. locked=1 after the 2nd wrap; rev_count=1,2,3…
- Inject 1100 while LOCKED → next cycle err_onehot=1, locked=0, phase_valid=0, FSM in FAULT. Legal samples afterwards leave the flags set. clr=1 → all cleared, IDLE.
- Drive 1000→0010 (skipped phase) in TRACK → err_seq=1, err_onehot=0, FAULT.
- Hold 0100 for 3 cycles in LOCKED: with RING_HOLD_ALLOW_EN, locked stays 1 and there are no errors; without it, err_seq=1 and FAULT.
- REV_W=2: run 5 wraps → rev_count=1,2,3,3,3; wrap_pulse asserted on all 5.
- Assert rst=0 asynchronously mid-cycle while LOCKED with rev_count=5 → all outputs 0 immediately, without waiting for a clk edge. Release, drive 0010 → TRACK, phase=2, phase_valid=1, no errors.
